note_sequencer: RTL and testbench

- Melody controller for the DE1-SoC iPod player. Steps through a song held in a synchronous on-chip ROM and drives the 32-bit divisor input of the tone clock divider.
- Holds each note for a programmed duration, then inserts a short silence gap before the next note.
- Supports start, stop, pause and loop control from the board keys.

---
 rtl/note_sequencer_pkg.sv | 51 +++++
 rtl/note_sequencer_lut.sv | 15 +
 rtl/note_sequencer.sv | 145 ++++++++++++++
 tb/tb_note_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the song sequencer and the keyboard-play path:
// note codes, divisor derivation, ROM word layout and FSM encoding.
package note_sequencer_pkg;

  localparam int unsigned DIV_W          = 32;
  localparam int unsigned CODE_W         = 4;
  localparam int unsigned UNITS_W        = 4;
  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  localparam logic [CODE_W-1:0] NOTE_DO1 = 4'b0001;
  localparam logic [CODE_W-1:0] NOTE_RE  = 4'b0011;
  localparam logic [CODE_W-1:0] NOTE_MI  = 4'b0101;
  localparam logic [CODE_W-1:0] NOTE_FA  = 4'b1001;
  localparam logic [CODE_W-1:0] NOTE_SOL = 4'b0111;
  localparam logic [CODE_W-1:0] NOTE_LA  = 4'b1011;
  localparam logic [CODE_W-1:0] NOTE_SI  = 4'b1101;
  localparam logic [CODE_W-1:0] NOTE_DO2 = 4'b1111;

  localparam logic [DIV_W-1:0] NO_SOUND   = '0;
  localparam logic [7:0]       END_MARKER = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic [UNITS_W-1:0] units;
  } rom_word_t;

  // Divisor = clk_hz / tone frequency, truncated; unknown codes are rests.
  function automatic logic [DIV_W-1:0] note_divisor(input logic [CODE_W-1:0] code,
                                                    input int unsigned clk_hz);
    case (code)
      NOTE_DO1: note_divisor = DIV_W'(clk_hz / 523);
      NOTE_RE:  note_divisor = DIV_W'(clk_hz / 587);
      NOTE_MI:  note_divisor = DIV_W'(clk_hz / 659);
      NOTE_FA:  note_divisor = DIV_W'(clk_hz / 698);
      NOTE_SOL: note_divisor = DIV_W'(clk_hz / 783);
      NOTE_LA:  note_divisor = DIV_W'(clk_hz / 880);
      NOTE_SI:  note_divisor = DIV_W'(clk_hz / 987);
      NOTE_DO2: note_divisor = DIV_W'(clk_hz / 1046);
      default:  note_divisor = NO_SOUND;
    endcase
  endfunction

endpackage

// File: rtl/note_sequencer_lut.sv
// Combinational note code to tone divisor lookup; shared with keyboard play.
module note_lut
  import note_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic [3:0]  code,
  output logic [31:0] divisor_c
);

  always_comb begin
    divisor_c = note_divisor(code, CLK_HZ);
  end

endmodule

// File: rtl/note_sequencer.sv
// Song ROM sequencer: fetches note words, holds each tone for its duration,
// then inserts a silence gap. Start/stop/pause/loop control from board keys.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned GAP_CYCLES = 500_000,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_data,
  output logic [31:0]       divisor,
  output logic              playing,
  output logic              note_strobe,
  output logic              done
);

  localparam logic [31:0] TICK_W   = 32'(TICK_DIV);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  code_q;
  logic [31:0] dur_cnt;
  logic [31:0] gap_cnt;

  rom_word_t   word_c;
  logic [31:0] units_c;
  logic [31:0] dur_load_c;
  logic [3:0]  lut_code_c;
  logic [31:0] lut_div_c;

  // A zero units field stands for the longest note, 16 units.
  always_comb begin
    word_c     = rom_word_t'(rom_data);
    units_c    = (word_c.units == 4'd0) ? 32'd16 : 32'(word_c.units);
    dur_load_c = (units_c * TICK_W) - 32'd1;
    lut_code_c = (state == ST_LOAD) ? word_c.code : code_q;
  end

  note_lut #(
    .CLK_HZ(CLK_HZ)
  ) u_note_lut (
    .code      (lut_code_c),
    .divisor_c (lut_div_c)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= ST_IDLE;
      code_q      <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      rom_addr    <= '0;
      rom_rd      <= 1'b0;
      divisor     <= NO_SOUND;
      playing     <= 1'b0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      rom_rd      <= 1'b0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        rom_addr <= '0;
        divisor  <= NO_SOUND;
        playing  <= 1'b0;
        dur_cnt  <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            divisor <= NO_SOUND;
            if (start) begin
              state    <= ST_FETCH;
              rom_addr <= '0;
              rom_rd   <= 1'b1;
              playing  <= 1'b1;
            end
          end
          ST_FETCH: begin
            state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (rom_data == END_MARKER) begin
              if (loop_en) begin
                state    <= ST_FETCH;
                rom_addr <= '0;
                rom_rd   <= 1'b1;
              end else begin
                state   <= ST_IDLE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              state       <= ST_PLAY;
              code_q      <= word_c.code;
              divisor     <= lut_div_c;
              dur_cnt     <= dur_load_c;
              note_strobe <= 1'b1;
            end
          end
          // Pause silences the tone but keeps the count; release restores it.
          ST_PLAY: begin
            if (pause) begin
              divisor <= NO_SOUND;
            end else if (dur_cnt == 32'd0) begin
              state   <= ST_GAP;
              divisor <= NO_SOUND;
              gap_cnt <= GAP_LOAD;
            end else begin
              dur_cnt <= dur_cnt - 32'd1;
              divisor <= lut_div_c;
            end
          end
          ST_GAP: begin
            if (!pause) begin
              if (gap_cnt == 32'd0) begin
                state    <= ST_FETCH;
                rom_addr <= rom_addr + ADDR_W'(1);
                rom_rd   <= 1'b1;
              end else begin
                gap_cnt <= gap_cnt - 32'd1;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            divisor <= NO_SOUND;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized and directed bench for note_sequencer against a song-level
// reference model that reads the song table and times notes directly.
module tb_note_sequencer;

  localparam int unsigned TICK  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [7:0]    rom_data = 8'h00;
  logic [31:0]   divisor;
  logic          playing;
  logic          note_strobe;
  logic          done;

  logic [7:0] rom_mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int act_cnt, strobe_cnt, done_cnt;

  always #5 clk_in = ~clk_in;

  note_sequencer #(
    .TICK_DIV   (TICK),
    .GAP_CYCLES (GAP),
    .ADDR_W     (AW)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .divisor     (divisor),
    .playing     (playing),
    .note_strobe (note_strobe),
    .done        (done)
  );

  // Synchronous song ROM, one cycle read latency.
  always @(posedge clk_in) begin
    if (rom_rd) rom_data <= rom_mem[rom_addr];
  end

  typedef enum int {M_IDLE, M_FETCH, M_LOAD, M_SOUND, M_SILENT} mphase_t;

  mphase_t     m_phase = M_IDLE;
  int          m_left = 0;
  int          m_addr = 0;
  logic [31:0] m_div = 0;
  logic [3:0]  m_code = 0;
  bit m_play = 0, m_strobe = 0, m_done = 0, m_rd = 0, m_addr_known = 0;

  function automatic logic [31:0] tone(input logic [3:0] code);
    case (code)
      4'b0001: return 32'd95602;
      4'b0011: return 32'd85178;
      4'b0101: return 32'd75872;
      4'b1001: return 32'd71633;
      4'b0111: return 32'd63856;
      4'b1011: return 32'd56818;
      4'b1101: return 32'd50658;
      4'b1111: return 32'd47801;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Outputs expected in the cycle after this clock edge.
  task automatic model_edge();
    logic [7:0] w;
    int units;
    m_strobe = 0;
    m_done   = 0;
    m_rd     = 0;
    if (reset || stop) begin
      m_phase = M_IDLE; m_addr = 0; m_div = 0; m_play = 0; m_left = 0;
      m_addr_known = 1;
    end else begin
      case (m_phase)
        M_IDLE: begin
          m_div = 0;
          if (start) begin
            m_phase = M_FETCH; m_addr = 0; m_rd = 1; m_play = 1; m_addr_known = 1;
          end
        end
        M_FETCH: m_phase = M_LOAD;
        M_LOAD: begin
          w = rom_mem[m_addr];
          if (w == 8'h00) begin
            if (loop_en) begin
              m_phase = M_FETCH; m_addr = 0; m_rd = 1;
            end else begin
              m_phase = M_IDLE; m_play = 0; m_done = 1; m_addr_known = 0;
            end
          end else begin
            units    = (w[3:0] == 0) ? 16 : int'(w[3:0]);
            m_left   = units * int'(TICK);
            m_code   = w[7:4];
            m_div    = tone(m_code);
            m_strobe = 1;
            m_phase  = M_SOUND;
          end
        end
        M_SOUND: begin
          if (pause) m_div = 0;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_phase = M_SILENT; m_left = int'(GAP); m_div = 0;
            end else m_div = tone(m_code);
          end
        end
        M_SILENT: begin
          if (!pause) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = M_FETCH; m_addr = (m_addr + 1) % int'(DEPTH); m_rd = 1;
            end
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_eq("divisor", divisor, m_div);
    check_eq("playing", 32'(playing), 32'(m_play));
    check_eq("note_strobe", 32'(note_strobe), 32'(m_strobe));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("rom_rd", 32'(rom_rd), 32'(m_rd));
    if (m_play || m_addr_known) check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    if (divisor != 0) act_cnt++;
    if (note_strobe) strobe_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    for (int i = 0; i < max && m_play; i++) tick();
    check_eq("idle_timeout", 32'(playing), 32'd0);
  endtask

  task automatic wait_strobe(input int max);
    for (int i = 0; i < max && !m_strobe; i++) tick();
    check_eq("strobe_timeout", 32'(note_strobe), 32'd1);
  endtask

  task automatic wait_phase(input mphase_t ph, input int max);
    for (int i = 0; i < max && m_phase != ph; i++) tick();
    check_eq("phase_timeout", 32'(m_phase == ph), 32'd1);
  endtask

  task automatic load_song(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = 8'h00;
    rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c;
  endtask

  task automatic load_random_song(input bit allow_end);
    for (int i = 0; i < int'(DEPTH); i++) begin
      rom_mem[i] = 8'($urandom);
      if (allow_end && $urandom_range(0, 5) == 0) rom_mem[i] = 8'h00;
      else if (rom_mem[i] == 8'h00) rom_mem[i] = 8'h13;
    end
  endtask

  initial begin
    load_song(8'h11, 8'h32, 8'h00);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();

    // Two-note song, no loop: expect two strobes and one done.
    act_cnt = 0; strobe_cnt = 0; done_cnt = 0;
    pulse_start();
    run_until_idle(200);
    tick();
    check_eq("song_strobes", 32'(strobe_cnt), 32'd2);
    check_eq("song_done", 32'(done_cnt), 32'd1);
    check_eq("song_active", 32'(act_cnt), 32'd12);

    // Loop: done never fires, song restarts from address 0.
    loop_en = 1'b1; done_cnt = 0;
    pulse_start();
    ticks(90);
    check_eq("loop_no_done", 32'(done_cnt), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    loop_en = 1'b0;
    tick();

    // Pause 5 cycles two cycles into an 8-cycle note.
    load_song(8'h12, 8'h00, 8'h00);
    act_cnt = 0;
    pulse_start();
    wait_strobe(10);
    tick();
    pause = 1'b1; ticks(5); pause = 1'b0;
    run_until_idle(100);
    check_eq("pause_active", 32'(act_cnt), 32'd8);

    // Stop mid-note.
    load_song(8'h11, 8'h32, 8'h00);
    pulse_start();
    wait_strobe(10);
    ticks(2);
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_playing", 32'(playing), 32'd0);
    ticks(3);

    // Rest code, then a zero-units note (16 units).
    load_song(8'h21, 8'h50, 8'h00);
    act_cnt = 0;
    pulse_start();
    run_until_idle(200);
    check_eq("rest_long_active", 32'(act_cnt), 32'd64);

    // Reset during a gap, then replay from address 0.
    load_song(8'h11, 8'h32, 8'h00);
    pulse_start();
    wait_phase(M_SILENT, 50);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("reset_addr", 32'(rom_addr), 32'd0);
    pulse_start();
    run_until_idle(200);

    // Wrap-around: full table without end marker, looping.
    load_random_song(1'b0);
    loop_en = 1'b1;
    pulse_start();
    ticks(1200);
    stop = 1'b1; tick(); stop = 1'b0;

    // Random control traffic over random songs.
    for (int seg = 0; seg < 8; seg++) begin
      load_random_song(1'b1);
      for (int c = 0; c < 400; c++) begin
        start = ($urandom_range(0, 19) == 0);
        stop  = ($urandom_range(0, 249) == 0);
        reset = ($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 9) == 0) pause = ~pause;
        if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
        tick();
      end
      start = 1'b0; reset = 1'b0; pause = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
